// File: rtl/alu_seq_unit.sv
// ---------------------------------------------------------------------------
// alu_seq_unit
//   Registered ALU with a valid/ready handshake on the request side and on the
//   result side. Most opcodes finish in one cycle. Popcount (0x8) and CRC (0x9)
//   run bit-serially over M CALC cycles, taking one bit of A per cycle, MSB first.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
//   high. The producer holds valid and the payload until that edge. o_valid
//   stays high, with a stable payload, until i_ready is sampled high.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_valid / o_ready     request handshake; o_ready is high only in IDLE
//   i_argA, i_argB        operands, captured on accept
//   i_oper                opcode, captured on accept
//   o_valid / i_ready     result handshake
//   o_result              registered result
//   o_PF, o_NF            parity / inverted parity of o_result
//   o_BF1, o_BF0          exactly one 1 / exactly one 0 in o_result
//   o_ERR                 illegal opcode
// ---------------------------------------------------------------------------
module alu_seq_unit #(
    parameter int M     = 8,
    parameter int N     = 4,
    parameter int CRC_W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [M-1:0] i_argA,
    input  logic [M-1:0] i_argB,
    input  logic [N-1:0] i_oper,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [M-1:0] o_result,
    output logic         o_PF,
    output logic         o_NF,
    output logic         o_BF1,
    output logic         o_BF0,
    output logic         o_ERR
);

    localparam int CNT_W = (M > 1) ? $clog2(M) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [N-1:0] OP_ADD   = N'(0);
    localparam logic [N-1:0] OP_OR    = N'(1);
    localparam logic [N-1:0] OP_NOR   = N'(2);
    localparam logic [N-1:0] OP_SHL   = N'(3);
    localparam logic [N-1:0] OP_SAR   = N'(4);
    localparam logic [N-1:0] OP_GRAY  = N'(5);
    localparam logic [N-1:0] OP_U1U2  = N'(6);
    localparam logic [N-1:0] OP_THERM = N'(7);
    localparam logic [N-1:0] OP_POP   = N'(8);
    localparam logic [N-1:0] OP_CRC   = N'(9);
    localparam logic [N-1:0] OP_PRIO  = N'(10);

    localparam logic [M-1:0]     LP_M    = M'(M);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(M - 1);

    // FSM and serial-engine state
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [M-1:0]     r_shift;   // captured A, shifted left so the MSB is the current bit
    logic [M-1:0]     r_acc;     // popcount accumulator
    logic [CRC_W-1:0] r_crc;     // CRC remainder register
    logic [CRC_W-1:0] r_poly;    // generator low bits (leading x^CRC_W is implicit)
    logic             r_is_crc;

    // Output registers
    logic [M-1:0] r_result;
    logic         r_pf;
    logic         r_nf;
    logic         r_bf1;
    logic         r_bf0;
    logic         r_err;

    // Single-cycle datapath, evaluated on the live inputs during IDLE
    logic signed [M-1:0] w_sar;
    logic [M-1:0]        w_prio;
    logic [M-1:0]        w_single;
    logic                w_illegal;
    logic                w_serial;

    // Serial step
    logic             w_bit;
    logic [M-1:0]     w_pop_next;
    logic             w_fb;
    logic [CRC_W-1:0] w_crc_next;
    logic [M-1:0]     w_calc_res;
    logic             w_last;
    logic [M-1:0]     w_res_load;

    assign o_ready  = (r_state == S_IDLE) & ~i_rst;
    assign o_valid  = (r_state == S_DONE);
    assign o_result = r_result;
    assign o_PF     = r_pf;
    assign o_NF     = r_nf;
    assign o_BF1    = r_bf1;
    assign o_BF0    = r_bf0;
    assign o_ERR    = r_err;

    // Kept in its own signed net so the surrounding unsigned mux cannot turn
    // the arithmetic shift into a logical one.
    assign w_sar = $signed(i_argA) >>> i_argB;

    always_comb begin
        w_prio = '1;
        for (int i = 0; i < M; i++) begin
            if (i_argA[i]) begin
                w_prio = M'(i);
            end
        end
    end

    always_comb begin
        w_single  = '0;
        w_illegal = 1'b0;
        w_serial  = 1'b0;
        case (i_oper)
            OP_ADD:   w_single = i_argA + i_argB;
            OP_OR:    w_single = i_argA | i_argB;
            OP_NOR:   w_single = ~(i_argA | i_argB);
            OP_SHL:   w_single = (i_argB >= LP_M) ? '0 : (i_argA << i_argB);
            OP_SAR: begin
                if (i_argB >= LP_M) begin
                    w_single = {M{i_argA[M-1]}};
                end else begin
                    w_single = w_sar;
                end
            end
            OP_GRAY:  w_single = i_argA ^ (i_argA >> 1);
            OP_U1U2:  w_single = i_argA[M-1] ? (i_argA + 1'b1) : i_argA;
            // A shift of M or more clears the mask, so the inversion saturates to all ones.
            OP_THERM: w_single = ~({M{1'b1}} << i_argA);
            OP_POP:   w_serial = 1'b1;
            OP_CRC:   w_serial = 1'b1;
            OP_PRIO:  w_single = w_prio;
            default:  w_illegal = 1'b1;
        endcase
    end

    // One bit of A per CALC cycle. The CRC step is the usual MSB-first LFSR,
    // which leaves (A * x^CRC_W) mod generator after M steps.
    assign w_bit      = r_shift[M-1];
    assign w_pop_next = r_acc + {{(M-1){1'b0}}, w_bit};
    assign w_fb       = r_crc[CRC_W-1] ^ w_bit;
    assign w_crc_next = {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? r_poly : '0);
    assign w_calc_res = r_is_crc ? {{(M-CRC_W){1'b0}}, w_crc_next} : w_pop_next;
    assign w_last     = (r_cnt == LP_LAST);
    assign w_res_load = (r_state == S_CALC) ? w_calc_res : w_single;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_acc    <= '0;
            r_crc    <= '0;
            r_poly   <= '0;
            r_is_crc <= 1'b0;
            r_result <= '0;
            r_pf     <= 1'b0;
            r_nf     <= 1'b0;
            r_bf1    <= 1'b0;
            r_bf0    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        if (w_serial) begin
                            r_state  <= S_CALC;
                            r_cnt    <= '0;
                            r_shift  <= i_argA;
                            r_acc    <= '0;
                            r_crc    <= '0;
                            r_poly   <= i_argB[CRC_W-1:0];
                            r_is_crc <= (i_oper == OP_CRC);
                        end else begin
                            r_state  <= S_DONE;
                            r_result <= w_res_load;
                            r_pf     <= ^w_res_load;
                            r_nf     <= ~^w_res_load;
                            r_bf1    <= $onehot(w_res_load);
                            r_bf0    <= $onehot(~w_res_load);
                            r_err    <= w_illegal;
                        end
                    end
                end
                S_CALC: begin
                    r_shift <= {r_shift[M-2:0], 1'b0};
                    r_acc   <= w_pop_next;
                    r_crc   <= w_crc_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state  <= S_DONE;
                        r_cnt    <= '0;
                        r_result <= w_res_load;
                        r_pf     <= ^w_res_load;
                        r_nf     <= ~^w_res_load;
                        r_bf1    <= $onehot(w_res_load);
                        r_bf0    <= $onehot(~w_res_load);
                        r_err    <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_unit
//   Directed cases followed by random operations. Each operation is checked
//   against an arithmetic reference model for result, flags, error, latency,
//   hold-while-stalled behaviour and handshake release.
// ---------------------------------------------------------------------------
module tb_alu_seq_unit;

    localparam int M     = 8;
    localparam int N     = 4;
    localparam int CRC_W = 4;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [M-1:0] i_argA;
    logic [M-1:0] i_argB;
    logic [N-1:0] i_oper;
    logic         o_valid;
    logic         i_ready;
    logic [M-1:0] o_result;
    logic         o_PF;
    logic         o_NF;
    logic         o_BF1;
    logic         o_BF0;
    logic         o_ERR;

    always #5 clk = ~clk;

    alu_seq_unit #(.M(M), .N(N), .CRC_W(CRC_W)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_argA   (i_argA),
        .i_argB   (i_argB),
        .i_oper   (i_oper),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_PF     (o_PF),
        .o_NF     (o_NF),
        .o_BF1    (o_BF1),
        .o_BF0    (o_BF0),
        .o_ERR    (o_ERR)
    );

    // ---------------- scoreboard ----------------
    int         n_chk = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];   // {err, result}

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic straight from the opcode table.
    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op, output logic err);
        int ua;
        int ub;
        int sa;
        int r;
        int v;
        int g;
        ua  = a;
        ub  = b;
        r   = 0;
        err = 1'b0;
        case (op)
            4'h0: r = ua + ub;
            4'h1: r = ua | ub;
            4'h2: r = ~(ua | ub);
            4'h3: r = (ub >= M) ? 0 : (ua << ub);
            4'h4: begin
                sa = (ua >= 128) ? ua - 256 : ua;
                r  = (ub >= M) ? ((sa < 0) ? 255 : 0) : (sa >>> ub);
            end
            4'h5: r = ua ^ (ua >> 1);
            4'h6: r = (ua >= 128) ? ua + 1 : ua;
            4'h7: r = (ua >= M) ? 255 : ((1 << ua) - 1);
            4'h8: begin
                for (int k = 0; k < M; k++) r += (ua >> k) & 1;
            end
            4'h9: begin
                // Polynomial long division of A * x^CRC_W by the generator.
                v = ua << CRC_W;
                g = (1 << CRC_W) | (ub & ((1 << CRC_W) - 1));
                for (int k = M + CRC_W - 1; k >= CRC_W; k--) begin
                    if (((v >> k) & 1) == 1) v = v ^ (g << (k - CRC_W));
                end
                r = v;
            end
            4'hA: begin
                r = 255;
                for (int k = 0; k < M; k++) if (((ua >> k) & 1) == 1) r = k;
            end
            default: begin
                r   = 0;
                err = 1'b1;
            end
        endcase
        return 8'(r);
    endfunction

    // {PF, NF, BF1, BF0, ERR} from a result value, by counting ones.
    function automatic logic [4:0] model_flags(input logic [7:0] r, input logic err);
        int ones;
        ones = 0;
        for (int k = 0; k < M; k++) ones += int'(r[k]);
        return {ones % 2 == 1, ones % 2 == 0, ones == 1, ones == M - 1, err};
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                          input int hold);
        int         w;
        int         lat;
        int         exp_lat;
        logic       err_m;
        logic [7:0] r_m;
        logic [8:0] e;

        w = 0;
        while (!o_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", 32'(o_ready), 32'd1);

        r_m = model(a, b, op, err_m);
        exp_q.push_back({err_m, r_m});
        i_valid = 1'b1;
        i_argA  = a;
        i_argB  = b;
        i_oper  = op;
        @(negedge clk);
        i_valid = 1'b0;

        // Inputs are scrambled while busy: they must be neither accepted nor used.
        lat = 1;
        while (!o_valid && lat < 40) begin
            chk("busy_ready", 32'(o_ready), 32'd0);
            i_valid = 1'($urandom_range(0, 1));
            i_argA  = 8'($urandom);
            i_argB  = 8'($urandom);
            i_oper  = 4'($urandom);
            @(negedge clk);
            lat++;
        end
        i_valid = 1'b0;

        e       = exp_q.pop_front();
        exp_lat = (op == 4'h8 || op == 4'h9) ? M + 1 : 1;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("result", 32'(o_result), 32'(e[7:0]));
        chk("flags", 32'({o_PF, o_NF, o_BF1, o_BF0, o_ERR}), 32'(model_flags(e[7:0], e[8])));
        chk("done_ready", 32'(o_ready), 32'd0);

        for (int h = 0; h < hold; h++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_argA  = 8'($urandom);
            i_oper  = 4'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_ready", 32'(o_ready), 32'd0);
            chk("hold_result", 32'(o_result), 32'(e[7:0]));
            chk("hold_flags", 32'({o_PF, o_NF, o_BF1, o_BF0, o_ERR}),
                32'(model_flags(e[7:0], e[8])));
        end
        i_valid = 1'b0;

        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        chk("release_valid", 32'(o_valid), 32'd0);
        chk("release_ready", 32'(o_ready), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [3:0] rop;

        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_argA  = '0;
        i_argB  = '0;
        i_oper  = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({o_valid, o_result, o_PF, o_NF, o_BF1, o_BF0, o_ERR, o_ready}),
            32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_release_ready", 32'(o_ready), 32'd1);

        // Directed cases
        run_op(8'h7F, 8'h01, 4'h0, 0);
        run_op(8'h90, 8'h02, 4'h4, 0);
        run_op(8'h90, 8'h09, 4'h3, 0);
        run_op(8'hFE, 8'h00, 4'h6, 0);
        run_op(8'hB7, 8'h00, 4'h8, 1);
        run_op(8'hA5, 8'h03, 4'h9, 0);
        run_op(8'h03, 8'h00, 4'h7, 0);
        run_op(8'h0B, 8'h00, 4'h7, 0);
        run_op(8'h00, 8'h00, 4'hA, 0);
        run_op(8'h90, 8'h0C, 4'h4, 0);
        run_op(8'h00, 8'h00, 4'hF, 3);
        run_op(8'hFF, 8'hFF, 4'h8, 0);

        // Reset in the middle of a popcount: everything clears at once.
        i_valid = 1'b1;
        i_argA  = 8'hB7;
        i_oper  = 4'h8;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midcalc_reset", 32'({o_valid, o_result, o_PF, o_NF, o_BF1, o_BF0, o_ERR, o_ready}),
            32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midcalc_release_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        run_op(8'h5A, 8'h13, 4'h9, 0);
        run_op(8'h12, 8'h34, 4'h1, 0);

        // Random operations
        for (int t = 0; t < 80; t++) begin
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            rop = 4'($urandom_range(0, 15));
            run_op(ra, rb, rop, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
